// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid buffer,
// flush, and a forwarding view of the main register.
module ex_mem_skid_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [M_W-1:0]    in_mem,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [M_W-1:0]    out_mem,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_dst,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    mem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  dst;
  } entry_t;

  entry_t in_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   skid_valid;
  logic   out_valid_d, skid_valid_d;
  logic   accept, main_free;

  assign in_entry  = '{wb: in_wb, mem: in_mem, alu: in_alu, wdata: in_wdata, dst: in_dst};
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;

  // Next-state: flush wins; otherwise refill main from skid first to keep FIFO order.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d      = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // in_ready and occupancy are registered from the next-state valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      occupancy  <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      out_valid  <= out_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= ~skid_valid_d;
      occupancy  <= OCC_W'(out_valid_d) + OCC_W'(skid_valid_d);
    end
  end

  // Control fields read as a bubble whenever the main register is empty.
  assign out_wb       = out_valid ? main_q.wb  : '0;
  assign out_mem      = out_valid ? main_q.mem : '0;
  assign out_alu      = main_q.alu;
  assign out_wdata    = main_q.wdata;
  assign out_dst      = main_q.dst;
  assign out_memread  = out_mem[M_W-1];
  assign out_memwrite = out_mem[0];

  assign fwd_en   = out_valid & main_q.wb[WB_W-1];
  assign fwd_dst  = main_q.dst;
  assign fwd_data = main_q.alu;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed table-driven bench for ex_mem_skid_stage plus a FIFO-order scoreboard run.
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_wb, in_mem, out_wb, out_mem, occupancy;
  logic [31:0] in_alu, in_wdata, out_alu, out_wdata, fwd_data;
  logic [4:0]  in_dst, out_dst, fwd_dst;
  logic        out_memread, out_memwrite, fwd_en;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb(in_wb), .in_mem(in_mem), .in_alu(in_alu), .in_wdata(in_wdata), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb(out_wb), .out_mem(out_mem), .out_alu(out_alu), .out_wdata(out_wdata), .out_dst(out_dst),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .fwd_en(fwd_en), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [1:0]  wb, mem;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic        chk;
    logic [31:0] e_alu;
    logic [1:0]  e_wb, e_mem;
    logic        e_fen;
    logic [4:0]  e_fdst;
  } vec_t;

  function automatic vec_t mk(input logic rst, fl, iv, ordy, input logic [1:0] wb, mem,
                              input logic [31:0] alu, input logic [4:0] dst,
                              input logic e_ov, e_ir, input logic [1:0] e_occ, input logic chk,
                              input logic [31:0] e_alu, input logic [1:0] e_wb, e_mem,
                              input logic e_fen, input logic [4:0] e_fdst);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.wb = wb; v.mem = mem;
    v.alu = alu; v.dst = dst; v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
    v.chk = chk; v.e_alu = e_alu; v.e_wb = e_wb; v.e_mem = e_mem;
    v.e_fen = e_fen; v.e_fdst = e_fdst;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, fl, iv, ordy, input logic [1:0] wb, mem,
                       input logic [31:0] alu, input logic [4:0] dst);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_wb = wb; in_mem = mem; in_alu = alu; in_wdata = ~alu; in_dst = dst;
  endtask

  vec_t vecs[$];
  int unsigned q[$];

  initial begin
    vec_t v;
    logic [31:0] e_wdata;
    // reset held two cycles with in_valid high
    vecs.push_back(mk(1,0,1,0, 2,1,'h99,9,     0,1,0,1, 'h0,   0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 2,1,'h99,9,     0,1,0,1, 'h0,   0,0,0,0));
    // streaming with out_ready high
    vecs.push_back(mk(0,0,1,1, 2,1,'h10,1,     1,1,1,1, 'h10,  2,1,1,1));
    vecs.push_back(mk(0,0,1,1, 2,1,'h20,2,     1,1,1,1, 'h20,  2,1,1,2));
    vecs.push_back(mk(0,0,1,1, 2,1,'h30,3,     1,1,1,1, 'h30,  2,1,1,3));
    vecs.push_back(mk(0,0,0,1, 2,1,'h31,4,     0,1,0,0, 'h0,   0,0,0,0));
    // backpressure into skid, then release
    vecs.push_back(mk(0,0,1,0, 2,1,'h10,1,     1,1,1,1, 'h10,  2,1,1,1));
    vecs.push_back(mk(0,0,1,0, 2,1,'h20,2,     1,0,2,1, 'h10,  2,1,1,1));
    vecs.push_back(mk(0,0,1,0, 2,1,'h30,3,     1,0,2,1, 'h10,  2,1,1,1));
    vecs.push_back(mk(0,0,1,1, 2,1,'h30,3,     1,1,1,1, 'h20,  2,1,1,2));
    vecs.push_back(mk(0,0,1,1, 2,1,'h30,3,     1,1,1,1, 'h30,  2,1,1,3));
    vecs.push_back(mk(0,0,0,0, 2,1,'h35,4,     1,1,1,1, 'h30,  2,1,1,3));
    // fill to FULL, flush with a concurrent input
    vecs.push_back(mk(0,0,1,0, 2,1,'h50,5,     1,0,2,1, 'h30,  2,1,1,3));
    vecs.push_back(mk(0,1,1,0, 2,1,'h40,6,     0,1,0,0, 'h0,   0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 2,1,'h41,6,     0,1,0,0, 'h0,   0,0,0,0));
    // forwarding with and without RegWrite
    vecs.push_back(mk(0,0,1,1, 2,0,'hDEAD,7,   1,1,1,1, 'hDEAD,2,0,1,7));
    vecs.push_back(mk(0,0,1,1, 0,0,'hBEEF,7,   1,1,1,1, 'hBEEF,0,0,0,7));
    // stall to FULL, then reset mid-stall
    vecs.push_back(mk(0,0,1,0, 2,3,'h60,8,     1,0,2,1, 'hBEEF,0,0,0,7));
    vecs.push_back(mk(1,0,1,0, 2,1,'h70,9,     0,1,0,1, 'h0,   0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 2,1,'h71,9,     0,1,0,1, 'h0,   0,0,0,0));
    // flush while ONE and draining
    vecs.push_back(mk(0,0,1,1, 2,1,'h80,1,     1,1,1,1, 'h80,  2,1,1,1));
    vecs.push_back(mk(0,1,1,1, 2,1,'h81,2,     0,1,0,0, 'h0,   0,0,0,0));

    drive(1,0,0,0, 0,0,0,0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.rst, v.fl, v.iv, v.ordy, v.wb, v.mem, v.alu, v.dst);
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(v.e_ov));
      check("in_ready",  i, 32'(in_ready),  32'(v.e_ir));
      check("occupancy", i, 32'(occupancy), 32'(v.e_occ));
      check("out_wb",    i, 32'(out_wb),    32'(v.e_wb));
      check("out_mem",   i, 32'(out_mem),   32'(v.e_mem));
      check("memrd_wr",  i, 32'({out_memread, out_memwrite}), 32'(v.e_mem));
      check("fwd_en",    i, 32'(fwd_en),    32'(v.e_fen));
      if (v.chk) begin
        e_wdata = (v.e_alu == 32'h0) ? 32'h0 : ~v.e_alu;
        check("out_alu",   i, out_alu,   v.e_alu);
        check("fwd_data",  i, fwd_data,  v.e_alu);
        check("out_wdata", i, out_wdata, e_wdata);
        check("out_dst",   i, 32'(out_dst), 32'(v.e_fdst));
        check("fwd_dst",   i, 32'(fwd_dst), 32'(v.e_fdst));
      end
    end

    // FIFO-order run: irregular in_valid/out_ready, every drained entry must match the queue head
    begin
      int unsigned sent = 0;
      int unsigned cyc  = 0;
      logic acc, drn;
      logic [31:0] head;
      while ((sent < 30 || q.size() != 0) && cyc < 400) begin
        @(negedge clk);
        drive(0, 0, (sent < 30) && (cyc % 5 != 4), (cyc % 3 != 1) || (sent >= 30),
              2, 1, 32'h1000 + 32'(sent), 5'(sent));
        acc  = in_valid & in_ready;
        drn  = out_valid & out_ready;
        head = out_alu;
        @(posedge clk);
        #1;
        if (drn) begin
          if (q.size() == 0) check("fifo_underflow", int'(cyc), 32'(1), 32'(0));
          else check("fifo_order", int'(cyc), head, q.pop_front());
        end
        if (acc) begin
          q.push_back(32'h1000 + sent);
          sent++;
        end
        check("fifo_occ", int'(cyc), 32'(occupancy), 32'(q.size()));
        cyc++;
      end
      check("fifo_done", int'(cyc), 32'(q.size() == 0 && sent == 30), 32'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
